// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per
// cycle, with the sign applied in a final FIX cycle. Divide-by-zero and signed
// overflow bypass the iteration and complete one cycle after acceptance.
module muldiv_unit #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 kill,
    input  logic [2:0]           funct3,
    input  logic [WORD_SIZE-1:0] rs1_val,
    input  logic [WORD_SIZE-1:0] rs2_val,
    input  logic [4:0]           rd_in,
    output logic                 busy,
    output logic                 done,
    output logic                 wb_en,
    output logic [4:0]           rd_out,
    output logic [WORD_SIZE-1:0] result
);
    localparam int W  = WORD_SIZE;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state, state_nxt;
    logic [2:0]     op;
    logic [4:0]     rd_q;
    logic           neg;
    logic [W-1:0]   opnd;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  cnt;

    // Absolute value of an operand when it is interpreted as signed.
    function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v,
                                               input logic is_signed);
        if (is_signed && v < 0) return ~v + W'(1);
        return v;
    endfunction

    // Apply the recorded sign and pick the word the operation returns.
    function automatic logic [W-1:0] fix_result(input logic [2:0] f, input logic n,
                                                input logic [2*W-1:0] a);
        logic [2*W-1:0] prod;
        logic [W-1:0]   quo;
        logic [W-1:0]   rem;
        prod = n ? (~a + (2*W)'(1)) : a;
        quo  = n ? (~a[W-1:0] + W'(1)) : a[W-1:0];
        rem  = n ? (~a[2*W-1:W] + W'(1)) : a[2*W-1:W];
        case (f)
            3'b000:         return prod[W-1:0];
            3'b100, 3'b101: return quo;
            3'b110, 3'b111: return rem;
            default:        return prod[2*W-1:W];
        endcase
    endfunction

    // Operand decode at acceptance: signedness, magnitudes and fast paths.
    logic         a_signed, b_signed, a_neg, b_neg, is_div, div_zero, ovf, fast;
    logic [W-1:0] a_mag, b_mag, fast_val;

    assign is_div   = funct3[2];
    assign a_signed = !(funct3 == 3'b011 || funct3 == 3'b101 || funct3 == 3'b111);
    assign b_signed = (funct3 == 3'b000 || funct3 == 3'b001 ||
                       funct3 == 3'b100 || funct3 == 3'b110);
    assign a_neg    = a_signed && rs1_val[W-1];
    assign b_neg    = b_signed && rs2_val[W-1];
    assign a_mag    = magnitude(rs1_val, a_signed);
    assign b_mag    = magnitude(rs2_val, b_signed);
    assign div_zero = is_div && (rs2_val == '0);
    assign ovf      = is_div && !funct3[0] && (rs1_val == {1'b1, {(W-1){1'b0}}}) &&
                      (rs2_val == '1);
    assign fast     = div_zero || ovf;
    assign fast_val = div_zero ? (funct3[1] ? rs1_val : '1)
                               : (funct3[1] ? '0 : {1'b1, {(W-1){1'b0}}});

    // One iteration step: acc holds {partial, multiplier} or {remainder, dividend/quotient}.
    logic [W:0]     msum, shifted;
    logic [W-1:0]   trial, rem_new;
    logic           ge;
    logic [2*W-1:0] mul_nxt, div_nxt;

    assign msum    = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_nxt = {msum, acc[W-1:1]};
    assign shifted = {acc[2*W-1:W], acc[W-1]};
    assign ge      = shifted >= {1'b0, opnd};
    assign trial   = shifted[W-1:0] - opnd;
    assign rem_new = ge ? trial : shifted[W-1:0];
    assign div_nxt = {rem_new, acc[W-2:0], ge};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state and status outputs; DONE doubles as an accept slot so a held
    // start is taken on the edge that ends the completion cycle.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        wb_en     = (state == DONE) && (rd_out != 5'd0);
        if (kill) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = fast ? DONE : CALC;
                CALC:    if (cnt == LAST) state_nxt = FIX;
                FIX:     state_nxt = DONE;
                DONE:    state_nxt = start ? (fast ? DONE : CALC) : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: latch on accept, iterate in CALC, commit result in FIX; kill freezes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op     <= '0;
            rd_q   <= '0;
            neg    <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
            rd_out <= '0;
            result <= '0;
        end else if (!kill) begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op   <= funct3;
                        rd_q <= rd_in;
                        neg  <= (funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
                        cnt  <= '0;
                        if (fast) begin
                            result <= fast_val;
                            rd_out <= rd_in;
                        end else if (is_div) begin
                            opnd <= b_mag;
                            acc  <= {{W{1'b0}}, a_mag};
                        end else begin
                            opnd <= a_mag;
                            acc  <= {{W{1'b0}}, b_mag};
                        end
                    end
                end
                CALC: begin
                    acc <= op[2] ? div_nxt : mul_nxt;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    result <= fix_result(op, neg, acc);
                    rd_out <= rd_q;
                end
                default: ;
            endcase
        end
    end
endmodule
